// File: rtl/buffer_fifo.sv
// buffer_fifo: first-word-fall-through FIFO that queues producer words
// (set & enable) for a consumer popping with take. Tracks occupancy, full,
// sticky overflow/underflow, and can either drop new words or evict the
// oldest entry when full. depth must be a power of two and addrwidth must
// equal log2(depth) so the pointers wrap naturally.
module buffer_fifo #(
    parameter int bitwidth  = 24,
    parameter int depth     = 16,
    parameter int addrwidth = 4,
    parameter bit overwrite = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 set,
    input  logic [bitwidth-1:0]  data,
    input  logic                 take,
    output logic [bitwidth-1:0]  q,
    output logic                 avail,
    output logic                 full,
    output logic [addrwidth:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [addrwidth:0]   full_count = (addrwidth+1)'(depth);
    localparam logic [addrwidth:0]   count_one  = (addrwidth+1)'(1);
    localparam logic [addrwidth-1:0] ptr_one    = addrwidth'(1);

    logic [bitwidth-1:0]  mem [depth];
    logic [addrwidth-1:0] wr_ptr;
    logic [addrwidth-1:0] rd_ptr;

    logic wr;
    logic pop;
    logic do_store;
    logic inc_rd;

    assign wr  = set & enable;
    assign pop = take & avail;

    // A word is stored unless the FIFO is full with no pop and we are in
    // drop mode; in overwrite mode the read pointer is pushed past the
    // oldest slot so the new word takes its place.
    assign do_store = wr & ~clear & (~full | pop | overwrite);
    assign inc_rd   = ~clear & (pop | (wr & full & overwrite));

    assign full  = (count == full_count);
    assign avail = (count != '0);
    assign q     = avail ? mem[rd_ptr] : '0;

    // Storage array; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clock) begin
        if (do_store) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers, occupancy and sticky flags, with async reset and sync flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_store) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (inc_rd) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
            case ({do_store, inc_rd})
                2'b10:   count <= count + count_one;
                2'b01:   count <= count - count_one;
                default: count <= count;
            endcase
            if (wr && full && !pop) begin
                overflow <= 1'b1;
            end
            if (take && !avail) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_fifo.sv
// Directed testbench for buffer_fifo: one drop-mode and one overwrite-mode
// instance share all inputs; each scenario task checks the relevant instance.
module tb_buffer_fifo;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic        enable;
    logic        set;
    logic [23:0] data;
    logic        take;

    logic [23:0] q0, q1;
    logic        avail0, avail1, full0, full1;
    logic [4:0]  count0, count1;
    logic        overflow0, overflow1, underflow0, underflow1;

    int checks = 0;
    int errors = 0;

    buffer_fifo #(.bitwidth(24), .depth(16), .addrwidth(4), .overwrite(1'b0)) dut_drop (
        .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
        .set(set), .data(data), .take(take), .q(q0), .avail(avail0),
        .full(full0), .count(count0), .overflow(overflow0), .underflow(underflow0)
    );

    buffer_fifo #(.bitwidth(24), .depth(16), .addrwidth(4), .overwrite(1'b1)) dut_ow (
        .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
        .set(set), .data(data), .take(take), .q(q1), .avail(avail1),
        .full(full1), .count(count1), .overflow(overflow1), .underflow(underflow1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        clear  = 1'b0;
        enable = 1'b0;
        set    = 1'b0;
        take   = 1'b0;
        data   = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic write_word(input logic [23:0] value);
        set = 1'b1; enable = 1'b1; data = value;
        step();
        set = 1'b0; enable = 1'b0;
    endtask

    task automatic fill(input int first, input int n);
        for (int i = 0; i < n; i++) write_word(24'(first + i));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if (count0 !== 5'd0 || avail0 !== 1'b0 || q0 !== 24'd0) begin
            errors++;
            $display("[TB] FAIL reset_in: count=%0d avail=%b q=%h expected 0/0/0", count0, avail0, q0);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (avail0 !== 1'b0 || full0 !== 1'b0 || count0 !== 5'd0 ||
            overflow0 !== 1'b0 || underflow0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: avail=%b full=%b count=%0d ovf=%b unf=%b expected all 0",
                     avail0, full0, count0, overflow0, underflow0);
        end
        set = 1'b1; enable = 1'b0; data = 24'h123456;
        for (int i = 0; i < 3; i++) step();
        set = 1'b0;
        checks++;
        if (count0 !== 5'd0 || avail0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL enable_gate: count=%0d avail=%b expected 0/0", count0, avail0);
        end
    endtask

    task automatic test_ordering();
        do_clear();
        fill(1, 16);
        checks++;
        if (full0 !== 1'b1 || count0 !== 5'd16) begin
            errors++;
            $display("[TB] FAIL order_full: full=%b count=%0d expected 1/16", full0, count0);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (q0 !== 24'(i)) begin
                errors++;
                $display("[TB] FAIL order_q[%0d]: got %h expected %h", i, q0, 24'(i));
            end
            take = 1'b1;
            step();
            take = 1'b0;
        end
        checks++;
        if (avail0 !== 1'b0 || count0 !== 5'd0 || underflow0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL order_empty: avail=%b count=%0d unf=%b expected 0/0/0", avail0, count0, underflow0);
        end
    endtask

    task automatic test_drop();
        do_clear();
        fill(1, 16);
        write_word(24'hABCDEF);
        checks++;
        if (overflow0 !== 1'b1 || count0 !== 5'd16) begin
            errors++;
            $display("[TB] FAIL drop_ovf: ovf=%b count=%0d expected 1/16", overflow0, count0);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (q0 !== 24'(i)) begin
                errors++;
                $display("[TB] FAIL drop_q[%0d]: got %h expected %h", i, q0, 24'(i));
            end
            take = 1'b1;
            step();
            take = 1'b0;
        end
        checks++;
        if (avail0 !== 1'b0 || overflow0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_end: avail=%b ovf=%b expected 0/1", avail0, overflow0);
        end
    endtask

    task automatic test_overwrite();
        do_clear();
        fill(1, 16);
        write_word(24'd17);
        write_word(24'd18);
        checks++;
        if (count1 !== 5'd16 || overflow1 !== 1'b1 || full1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ow_state: count=%0d ovf=%b full=%b expected 16/1/1", count1, overflow1, full1);
        end
        for (int i = 3; i <= 18; i++) begin
            checks++;
            if (q1 !== 24'(i)) begin
                errors++;
                $display("[TB] FAIL ow_q[%0d]: got %h expected %h", i, q1, 24'(i));
            end
            take = 1'b1;
            step();
            take = 1'b0;
        end
        checks++;
        if (count1 !== 5'd0 || avail1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ow_empty: count=%0d avail=%b expected 0/0", count1, avail1);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        fill(24'h100, 5);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (q0 !== 24'(24'h100 + i) || count0 !== 5'd5) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]: q=%h count=%0d expected %h/5", i, q0, count0, 24'(24'h100 + i));
            end
            set = 1'b1; enable = 1'b1; take = 1'b1; data = 24'(24'h105 + i);
            step();
        end
        set = 1'b0; enable = 1'b0; take = 1'b0;
        checks++;
        if (q0 !== 24'h114 || count0 !== 5'd5 || q1 !== 24'h114) begin
            errors++;
            $display("[TB] FAIL b2b_end: q0=%h q1=%h count=%0d expected 114/114/5", q0, q1, count0);
        end
    endtask

    task automatic test_full_simultaneous();
        do_clear();
        fill(24'h200, 16);
        set = 1'b1; enable = 1'b1; take = 1'b1; data = 24'h2FF;
        step();
        set = 1'b0; enable = 1'b0; take = 1'b0;
        checks++;
        if (overflow0 !== 1'b0 || count0 !== 5'd16 || full0 !== 1'b1 || q0 !== 24'h201) begin
            errors++;
            $display("[TB] FAIL full_rw_drop: ovf=%b count=%0d full=%b q=%h expected 0/16/1/201",
                     overflow0, count0, full0, q0);
        end
        checks++;
        if (overflow1 !== 1'b0 || count1 !== 5'd16 || q1 !== 24'h201) begin
            errors++;
            $display("[TB] FAIL full_rw_ow: ovf=%b count=%0d q=%h expected 0/16/201", overflow1, count1, q1);
        end
    endtask

    task automatic test_underflow();
        do_clear();
        take = 1'b1;
        step();
        take = 1'b0;
        checks++;
        if (underflow0 !== 1'b1 || count0 !== 5'd0) begin
            errors++;
            $display("[TB] FAIL underflow: unf=%b count=%0d expected 1/0", underflow0, count0);
        end
        do_clear();
        take = 1'b1; set = 1'b1; enable = 1'b1; data = 24'h000055;
        step();
        take = 1'b0; set = 1'b0; enable = 1'b0;
        checks++;
        if (underflow0 !== 1'b1 || count0 !== 5'd1 || q0 !== 24'h000055) begin
            errors++;
            $display("[TB] FAIL underflow_write: unf=%b count=%0d q=%h expected 1/1/000055",
                     underflow0, count0, q0);
        end
    endtask

    task automatic test_clear();
        do_clear();
        take = 1'b1;
        step();
        take = 1'b0;
        fill(24'h300, 7);
        clear = 1'b1; set = 1'b1; enable = 1'b1; data = 24'hDEAD00;
        step();
        clear = 1'b0; set = 1'b0; enable = 1'b0;
        checks++;
        if (count0 !== 5'd0 || avail0 !== 1'b0 || underflow0 !== 1'b0 || overflow0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear: count=%0d avail=%b unf=%b ovf=%b expected 0/0/0/0",
                     count0, avail0, underflow0, overflow0);
        end
        write_word(24'h000777);
        checks++;
        if (count0 !== 5'd1 || q0 !== 24'h000777) begin
            errors++;
            $display("[TB] FAIL clear_resume: count=%0d q=%h expected 1/000777", count0, q0);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        fill(24'h400, 9);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count0 !== 5'd0 || avail0 !== 1'b0 || count1 !== 5'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: count0=%0d avail=%b count1=%0d expected 0/0/0",
                     count0, avail0, count1);
        end
        reset_n = 1'b1;
        write_word(24'h000ABC);
        checks++;
        if (count0 !== 5'd1 || q0 !== 24'h000ABC) begin
            errors++;
            $display("[TB] FAIL async_resume: count=%0d q=%h expected 1/000ABC", count0, q0);
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_drop();
        test_overwrite();
        test_back_to_back();
        test_full_simultaneous();
        test_underflow();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_fifo.md
Name: buffer_fifo

Overview:
- Parametrised multi-entry successor to the single-word latch buffer used for ADC, PMT and counter results.
- Queues up to `depth` words from a producer strobe (`set` gated by `enable`) for a consumer that pops them with `take`.
- Adds occupancy count, full indication, sticky overflow/underflow flags and a selectable overwrite-oldest mode.
- Sits between a data source and the pipe/register readout logic.

Parameters:
- bitwidth, 24, data word width in bits.
- depth, 16, number of entries; must be a power of two, minimum 2.
- addrwidth, 4, log2(depth); must match depth.
- overwrite, 0, full-policy: 0 = drop the incoming word when full; 1 = discard the oldest entry and store the new word.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; empties the FIFO and clears flags.
- enable  input  1  write qualifier; a write occurs only when set & enable.
- set  input  1  write strobe.
- data  input  bitwidth  word to store.
- take  input  1  pop strobe; removes the head entry.
- q  output  bitwidth  head entry; valid only while avail=1.
- avail  output  1  FIFO non-empty (count != 0).
- full  output  1  count == depth.
- count  output  addrwidth+1  number of stored entries, 0..depth.
- overflow  output  1  sticky; a write arrived while full without a same-cycle pop.
- underflow  output  1  sticky; take arrived while empty.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Pointers and count go to 0.
  - avail=0, full=0, overflow=0, underflow=0, q=0.
  - Storage contents are don't-care.
- Storage is a register array. q is driven combinationally from mem[rd_ptr], so it is first-word-fall-through with no read latency.
- A write is wr = set & enable.
  - Stores data at wr_ptr, and wr_ptr increments modulo depth.
  - A write into an empty FIFO makes avail=1 and q=data on the following cycle.
- A pop is take & avail.
  - rd_ptr increments modulo depth.
  - The next entry appears on q the following cycle.
- Count update:
  - count+1 on write-only.
  - count-1 on pop-only.
  - Unchanged on simultaneous write and pop.
- Priority per cycle: reset_n > clear > write/pop.
  - clear=1 zeroes pointers, count, overflow and underflow, and ignores set/take in that cycle.
- Empty with take=1:
  - No pointer change; underflow sets to 1.
  - If a write occurs in the same cycle, it is still accepted and count becomes 1.
- Full with write and no take:
  - overwrite=0: the word is dropped; pointers and count are unchanged; overflow sets to 1.
  - overwrite=1: the word is stored at wr_ptr (the oldest slot); wr_ptr and rd_ptr both increment; count stays depth; overflow sets to 1.
- Full with write and take together: both are performed, count stays depth, overflow is unaffected.
- Pointer wrap: pointers wrap from depth-1 to 0 with no gap. count must never exceed depth or go below 0.
- Derived outputs are decoded from the registered count:
  - full = (count == depth).
  - avail = (count != 0).
- Sticky flags clear only on reset_n=0 or clear=1.
- reset_n asserted mid-burst: all state goes to reset values immediately, without waiting for a clock edge. Operation resumes on the first rising edge after release.

Test Plan:
- Reset then idle: after release, avail=0, full=0, count=0, overflow=0, underflow=0. set=1 with enable=0 for 3 cycles leaves count=0.
- Ordering with depth=16, overwrite=0: write 0x000001..0x000010 → full=1, count=16. Pop 16 times → q sequence 0x000001..0x000010, then avail=0, count=0.
- Drop policy: fill with 1..16, then write 0xABCDEF → overflow=1, count=16. Popping yields 1..16 only; 0xABCDEF never appears.
- Overwrite policy (overwrite=1): fill with 1..16, then write 17 and 18 → count=16, overflow=1. Pops yield 3..18.
- Simultaneous and boundary events:
  - With count=5, set&take for 20 cycles → count stays 5, pointers wrap, data order preserved.
  - Full plus set&take → overflow stays 0.
  - Empty plus take → underflow=1.
- Clear and async reset:
  - clear=1 together with set=1 at count=7 → count=0 next cycle, flags 0, the word is not stored.
  - reset_n pulsed low between clock edges at count=9 → count=0 and avail=0 before the next edge.
